// File: rtl/ibex_multdiv_iter.sv
// ibex_multdiv_iter: iterative unsigned MUL/MULHU/DIVU/REMU unit.
// Computes 32 shift-add (multiply) or restoring-subtract (divide) steps
// on the ALU's shared adder, then presents a 32-bit result.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, kill_i, op_i   request, abort, op (00 MUL 01 MULHU 10 DIVU 11 REMU)
//   operand_a_i/b_i         operands, sampled on accepted start
//   alu_operand_a_o/b_o     operands into the ALU adder (LSB is carry slot)
//   multdiv_sel_o           ALU operand steering, high while iterating
//   alu_adder_ext_i         34-bit extended adder sum back from the ALU
//   busy_o, valid_o         in-flight flag, one-cycle completion pulse
//   result_o                final result, held until the next completion
module ibex_multdiv_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    output logic        multdiv_sel_o,
    input  logic [33:0] alu_adder_ext_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_p;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic [31:0] r_result;

    logic        w_is_div;
    logic [31:0] w_sh;
    logic        w_accept;
    logic [64:0] w_mul_next;
    logic [31:0] w_final;
    logic        w_done_ok;
    logic        w_unused;

    assign w_is_div = r_op[1];
    assign w_sh     = {r_r[30:0], r_q[31]};
    // R[31] set means the shifted remainder is >= 2^32 > B, so always subtract.
    assign w_accept = r_r[31] | alu_adder_ext_i[33];
    assign w_mul_next = {alu_adder_ext_i[33:1], r_q};
    // Bit 0 is the carry-in slot; it carries no sum information.
    assign w_unused = alu_adder_ext_i[0];

    always_comb begin
        alu_operand_a_o = 33'd0;
        alu_operand_b_o = 33'd0;
        if (r_state == S_CALC) begin
            if (w_is_div) begin
                // sh + ~B + 1 (carry from both LSB slots) = sh - B
                alu_operand_a_o = {w_sh, 1'b1};
                alu_operand_b_o = {~r_b, 1'b1};
            end else begin
                alu_operand_a_o = {r_p, 1'b1};
                alu_operand_b_o = {(r_q[0] ? r_a : 32'd0), 1'b0};
            end
        end
    end

    always_comb begin
        w_final = r_q;
        unique case (r_op)
            2'b00:   w_final = r_q;
            2'b01:   w_final = r_p;
            2'b10:   w_final = r_q;
            default: w_final = r_r;
        endcase
    end

    // The result is shown live during DONE so valid_o and result_o align.
    assign w_done_ok     = (r_state == S_DONE) && !kill_i && !rst_i;
    assign valid_o       = w_done_ok;
    assign result_o      = w_done_ok ? w_final : r_result;
    assign busy_o        = (r_state != S_IDLE);
    assign multdiv_sel_o = (r_state == S_CALC);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_op     <= 2'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_p      <= 32'd0;
            r_q      <= 32'd0;
            r_r      <= 32'd0;
            r_result <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i && !kill_i) begin
                        r_state <= S_CALC;
                        r_cnt   <= 5'd31;
                        r_op    <= op_i;
                        r_a     <= operand_a_i;
                        r_b     <= operand_b_i;
                        r_p     <= 32'd0;
                        r_r     <= 32'd0;
                        r_q     <= op_i[1] ? operand_a_i : operand_b_i;
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_is_div) begin
                            r_r <= w_accept ? alu_adder_ext_i[32:1] : w_sh;
                            r_q <= {r_q[30:0], w_accept};
                        end else begin
                            r_p <= w_mul_next[64:33];
                            r_q <= w_mul_next[32:1];
                        end
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd0) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (!kill_i) begin
                        r_result <= w_final;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// tb_ibex_multdiv_iter: randomized and directed checks of ibex_multdiv_iter
// against an arithmetic reference model, with a behavioural ALU adder.
module tb_ibex_multdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [32:0] alu_a;
    logic [32:0] alu_b;
    logic        sel;
    logic [33:0] adder_ext;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    assign adder_ext = {1'b0, alu_a} + {1'b0, alu_b};

    ibex_multdiv_iter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .kill_i          (kill),
        .op_i            (op),
        .operand_a_i     (opa),
        .operand_b_i     (opb),
        .alu_operand_a_o (alu_a),
        .alu_operand_b_o (alu_b),
        .multdiv_sel_o   (sel),
        .alu_adder_ext_i (adder_ext),
        .busy_o          (busy),
        .valid_o         (valid),
        .result_o        (result)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called in cycle 0 (after a negedge); returns in cycle 34 (IDLE).
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        logic ok;
        exp   = ref_model(o, a, b);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(negedge clk);
        start = 1'b0;
        ok    = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            if (!sel || !busy || valid) ok = 1'b0;
            @(negedge clk);
        end
        chk({tag, " calc_window"}, {63'd0, ok}, 64'd1);
        chk({tag, " valid33"}, {63'd0, valid}, 64'd1);
        chk({tag, " result"}, {32'd0, result}, {32'd0, exp});
        chk({tag, " sel33"}, {63'd0, sel}, 64'd0);
        @(negedge clk);
        chk({tag, " idle34"}, {62'd0, valid, busy}, 64'd0);
        chk({tag, " held"}, {32'd0, result}, {32'd0, exp});
        chk({tag, " alu_ops0"}, {alu_a[30:0], alu_b}, 64'd0);
        last_res = exp;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ok;
        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'd0;
        opa   = 32'd0;
        opb   = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {result, 29'd0, valid, busy, sel}, 64'd0);
        chk("reset_alu", {alu_a[30:0], alu_b}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul7x6", 2'b00, 32'd7, 32'd6);
        run_op("mulhu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("divu100_7", 2'b10, 32'd100, 32'd7);
        run_op("remu100_7", 2'b11, 32'd100, 32'd7);
        run_op("divu_big", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("remu_big", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("divu_by0", 2'b10, 32'h1234, 32'd0);
        run_op("remu_by0", 2'b11, 32'h1234, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op("rand", ro, ra, rb);
        end

        // start while busy is ignored
        start = 1'b1;
        op    = 2'b10;
        opa   = 32'd1000;
        opb   = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        opa   = 32'd3;
        opb   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(negedge clk);
        chk("busy_start valid", {63'd0, valid}, 64'd1);
        chk("busy_start result", {32'd0, result}, 64'd111);
        last_res = 32'd111;
        @(negedge clk);

        // kill at cycle 15, restart at cycle 16
        start = 1'b1;
        op    = 2'b00;
        opa   = 32'd3;
        opb   = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill idle", {61'd0, valid, busy, sel}, 64'd0);
        chk("kill held", {32'd0, result}, {32'd0, last_res});
        run_op("after_kill", 2'b01, 32'h80000000, 32'd6);

        // kill beats start in IDLE
        start = 1'b1;
        kill  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_prio", {62'd0, busy, sel}, 64'd0);

        // reset at cycle 20 mid-CALC
        start = 1'b1;
        op    = 2'b11;
        opa   = 32'd77;
        opb   = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid outs", {result, 29'd0, valid, busy, sel}, 64'd0);
        chk("rst_mid alu", {alu_a[30:0], alu_b}, 64'd0);
        rst = 1'b0;
        ok  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (valid || busy) ok = 1'b0;
            @(negedge clk);
        end
        chk("rst_mid no_valid", {63'd0, ok}, 64'd1);
        run_op("after_rst", 2'b10, 32'd77, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
